dac_spi_responder: RTL and testbench

DAC_SPI_RESPONDER -- requirements
Module: dac_spi_responder

---
 rtl/dac_spi_responder_pkg.sv | 46 ++++
 rtl/dac_spi_responder_sync_edge_detect.sv | 34 +++
 rtl/dac_spi_responder.sv | 183 ++++++++++++++++++
 tb/tb_dac_spi_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_responder_pkg.sv
// Shared definitions for the DAC SPI responder: command codes, channel masks,
// frame field positions, receive FSM encoding and the frame decode helper.
package dac_spi_responder_pkg;

  localparam int FRAME_LEN = 24;
  localparam int NUM_CH    = 4;

  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam logic [3:0] CMD_WRITE_INPUT      = 4'h0;
  localparam logic [3:0] CMD_UPDATE           = 4'h1;
  localparam logic [3:0] CMD_WRITE_UPDATE_ALL = 4'h2;
  localparam logic [3:0] CMD_WRITE_UPDATE     = 4'h3;

  localparam logic [3:0] DAC_A = 4'h1;
  localparam logic [3:0] DAC_B = 4'h2;
  localparam logic [3:0] DAC_C = 4'h4;
  localparam logic [3:0] DAC_D = 4'h8;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_COMMIT   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [15:0] data;
  } frame_t;

  function automatic frame_t decode_frame(input logic [FRAME_LEN-1:0] raw);
    frame_t f;
    f.cmd  = raw[CMD_MSB:CMD_LSB];
    f.addr = raw[ADDR_MSB:ADDR_LSB];
    f.data = raw[DATA_MSB:DATA_LSB];
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_responder_sync_edge_detect.sv
// 2-flop synchronizer plus a third registered copy for rise/fall pulses.
// Latency: 2 clk pin-to-sync, edge pulse coincident with the new sync level; no backpressure.
module sync_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/dac_spi_responder.sv
// SPI write-only responder driving four 16-bit DAC input/output register pairs with LDAC.
// Latency: ss pin rise to frame_valid 4 clk; no backpressure (frames are accepted unconditionally).
module dac_spi_responder #(
  parameter int CLK_PER_SCK_MIN = 4,
  parameter int FRAME_BITS      = 24
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ss,
  input  logic        i_sck,
  input  logic        i_mosi,
  input  logic        i_ldac_n,
  output logic [15:0] o_dac_a,
  output logic [15:0] o_dac_b,
  output logic [15:0] o_dac_c,
  output logic [15:0] o_dac_d,
  output logic        o_frame_valid,
  output logic [3:0]  o_frame_cmd,
  output logic [3:0]  o_frame_addr,
  output logic [15:0] o_frame_data,
  output logic        o_frame_error,
  output logic        o_cmd_error,
  output logic        o_busy
);
  import dac_spi_responder_pkg::*;

  localparam int              CNT_W   = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_OK  = CNT_W'(FRAME_BITS);
  localparam logic [3:0]      CH_MASK [NUM_CH] = '{DAC_A, DAC_B, DAC_C, DAC_D};

  // Field positions are fixed to a 24-bit frame; sck half-periods below 3 clk merge edges.
  if (FRAME_BITS != FRAME_LEN || CLK_PER_SCK_MIN < 3) begin : g_bad_param
    $error("dac_spi_responder: unsupported FRAME_BITS or CLK_PER_SCK_MIN");
  end

  logic w_ss_sync, w_ss_rise, w_ss_fall;
  logic w_sck_sync, w_sck_rise, w_sck_fall;
  logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
  logic w_ldac_sync, w_ldac_rise, w_ldac_fall;
  logic w_unused;

  sync_edge_detect #(.RST_VAL(1'b1)) u_sync_ss (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_ss),
    .o_sync(w_ss_sync), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );
  sync_edge_detect #(.RST_VAL(1'b0)) u_sync_sck (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_sck),
    .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  sync_edge_detect #(.RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_mosi),
    .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );
  sync_edge_detect #(.RST_VAL(1'b1)) u_sync_ldac (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_ldac_n),
    .o_sync(w_ldac_sync), .o_rise(w_ldac_rise), .o_fall(w_ldac_fall)
  );

  assign w_unused = &{1'b0, w_ss_fall, w_sck_sync, w_sck_fall, w_mosi_rise,
                      w_mosi_fall, w_ldac_sync, w_ldac_rise};

  rx_state_t              r_state, w_state_nxt;
  logic [1:0]             r_arm_cnt;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [15:0]            r_in  [NUM_CH];
  logic [15:0]            r_out [NUM_CH];
  logic [15:0]            w_in_nxt  [NUM_CH];
  logic [15:0]            w_out_nxt [NUM_CH];
  frame_t                 r_frame;
  frame_t                 w_frame;
  logic                   r_frame_valid, r_frame_error, r_cmd_error;
  logic                   w_commit, w_len_ok, w_accept, w_cmd_ok;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_DISARMED;
    else       r_state <= w_state_nxt;
  end

  // The synchronizer resets to "ss high"; arm only once that level has been refilled from the pin.
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_ss_sync) r_arm_cnt <= 2'd0;
    else if (r_arm_cnt != 2'd2) r_arm_cnt <= r_arm_cnt + 2'd1;
  end

  // IDLE is only ever entered with ss high, so a low level there means a fall happened,
  // including one that landed during COMMIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_DISARMED: if (w_ss_sync && r_arm_cnt == 2'd2) w_state_nxt = ST_IDLE;
      ST_IDLE:     if (!w_ss_sync) w_state_nxt = ST_SHIFT;
      ST_SHIFT:    if (w_ss_rise)  w_state_nxt = ST_COMMIT;
      ST_COMMIT:   w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_DISARMED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_bit_cnt <= '0;
    end else if (r_state == ST_SHIFT && w_sck_rise) begin
      r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi_sync};
      if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  assign w_commit = (r_state == ST_COMMIT);
  assign w_len_ok = (r_bit_cnt == CNT_OK);
  assign w_accept = w_commit & w_len_ok;
  assign w_frame  = decode_frame(r_shift);
  assign w_cmd_ok = (w_frame.cmd <= CMD_WRITE_UPDATE);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) w_in_nxt[i] = r_in[i];
    if (w_accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((w_frame.addr & CH_MASK[i]) != 4'h0) begin
          case (w_frame.cmd)
            CMD_WRITE_INPUT, CMD_WRITE_UPDATE_ALL, CMD_WRITE_UPDATE: w_in_nxt[i] = w_frame.data;
            default: ;
          endcase
        end
      end
    end
  end

  // LDAC copies post-write input values, so it agrees with a coincident 0x3 write.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) w_out_nxt[i] = r_out[i];
    if (w_accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (w_frame.cmd)
          CMD_UPDATE:
            if ((w_frame.addr & CH_MASK[i]) != 4'h0) w_out_nxt[i] = w_in_nxt[i];
          CMD_WRITE_UPDATE_ALL:
            w_out_nxt[i] = w_in_nxt[i];
          CMD_WRITE_UPDATE:
            if ((w_frame.addr & CH_MASK[i]) != 4'h0) w_out_nxt[i] = w_frame.data;
          default: ;
        endcase
      end
    end
    if (w_ldac_fall) begin
      for (int i = 0; i < NUM_CH; i++) w_out_nxt[i] = w_in_nxt[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in          <= '{default: '0};
      r_out         <= '{default: '0};
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_cmd_error   <= 1'b0;
    end else begin
      r_in          <= w_in_nxt;
      r_out         <= w_out_nxt;
      r_frame_valid <= w_accept;
      r_frame_error <= w_commit & ~w_len_ok;
      r_cmd_error   <= w_accept & ~w_cmd_ok;
      if (w_accept) r_frame <= w_frame;
    end
  end

  assign o_dac_a       = r_out[0];
  assign o_dac_b       = r_out[1];
  assign o_dac_c       = r_out[2];
  assign o_dac_d       = r_out[3];
  assign o_frame_valid = r_frame_valid;
  assign o_frame_cmd   = r_frame.cmd;
  assign o_frame_addr  = r_frame.addr;
  assign o_frame_data  = r_frame.data;
  assign o_frame_error = r_frame_error;
  assign o_cmd_error   = r_cmd_error;
  assign o_busy        = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed plus randomized frames against a register-level model of the DAC command set.
module tb_dac_spi_responder;

  logic        clk = 1'b0;
  logic        rst, ss, sck, mosi, ldac_n;
  logic [15:0] dac_a, dac_b, dac_c, dac_d, frame_data;
  logic [3:0]  frame_cmd, frame_addr;
  logic        frame_valid, frame_error, cmd_error, busy;

  dac_spi_responder #(.CLK_PER_SCK_MIN(4), .FRAME_BITS(24)) dut (
    .i_clk(clk), .i_rst(rst), .i_ss(ss), .i_sck(sck), .i_mosi(mosi), .i_ldac_n(ldac_n),
    .o_dac_a(dac_a), .o_dac_b(dac_b), .o_dac_c(dac_c), .o_dac_d(dac_d),
    .o_frame_valid(frame_valid), .o_frame_cmd(frame_cmd), .o_frame_addr(frame_addr),
    .o_frame_data(frame_data), .o_frame_error(frame_error), .o_cmd_error(cmd_error),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_in  [4];
  logic [15:0] m_out [4];
  logic [3:0]  m_cmd, m_addr;
  logic [15:0] m_data;

  int          ob_valid, ob_ferr, ob_cerr, ob_lat;
  logic [15:0] ob_dac_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_in[i] = '0; m_out[i] = '0; end
    m_cmd = '0; m_addr = '0; m_data = '0;
  endtask

  // A frame is cmd:addr:data; the addr bits pick channels A..D.
  task automatic model_frame(input logic [23:0] f);
    logic [3:0] c, a;
    logic [15:0] d;
    c = f[23:20]; a = f[19:16]; d = f[15:0];
    m_cmd = c; m_addr = a; m_data = d;
    for (int i = 0; i < 4; i++) begin
      if (a[i]) begin
        if (c == 4'h0 || c == 4'h2 || c == 4'h3) m_in[i] = d;
        if (c == 4'h1) m_out[i] = m_in[i];
        if (c == 4'h3) m_out[i] = d;
      end
    end
    if (c == 4'h2) for (int i = 0; i < 4; i++) m_out[i] = m_in[i];
  endtask

  task automatic model_ldac();
    for (int i = 0; i < 4; i++) m_out[i] = m_in[i];
  endtask

  // Leaves ss low; call at a falling clk edge.
  task automatic spi_bits(input logic [23:0] f, input int nbits, input int h);
    ss = 1'b0;
    repeat (h) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      mosi = f[23-b];
      repeat (h) @(negedge clk);
      sck = 1'b1;
      repeat (h) @(negedge clk);
      sck = 1'b0;
    end
    repeat (h) @(negedge clk);
  endtask

  // Raises ss and watches 10 cycles; ldac_n drops ldac_off cycles after ss when non-zero.
  task automatic finish_frame(input int ldac_off);
    ob_valid = 0; ob_ferr = 0; ob_cerr = 0; ob_lat = 0; ob_dac_c = 'x;
    ss = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == ldac_off) ldac_n = 1'b0;
      if (frame_valid) begin ob_valid++; ob_dac_c = dac_c; end
      if (frame_error) ob_ferr++;
      if (cmd_error) ob_cerr++;
      if ((frame_valid || frame_error) && ob_lat == 0) ob_lat = i;
    end
  endtask

  task automatic chk_pulses(input string tag, input int v, input int fe, input int ce);
    chk({tag, "_valid_pulses"}, ob_valid, v);
    chk({tag, "_frame_error_pulses"}, ob_ferr, fe);
    chk({tag, "_cmd_error_pulses"}, ob_cerr, ce);
    if (v + fe > 0) chk({tag, "_latency_le5"}, (ob_lat > 0 && ob_lat <= 5), 1);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_dac_a"}, dac_a, m_out[0]);
    chk({tag, "_dac_b"}, dac_b, m_out[1]);
    chk({tag, "_dac_c"}, dac_c, m_out[2]);
    chk({tag, "_dac_d"}, dac_d, m_out[3]);
    chk({tag, "_frame_cmd"}, frame_cmd, m_cmd);
    chk({tag, "_frame_addr"}, frame_addr, m_addr);
    chk({tag, "_frame_data"}, frame_data, m_data);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic full_frame(input string tag, input logic [23:0] f, input int h);
    spi_bits(f, 24, h);
    chk({tag, "_busy_in_frame"}, busy, 1);
    finish_frame(0);
    model_frame(f);
    chk_pulses(tag, 1, 0, (f[23:20] > 4'h3) ? 1 : 0);
    check_state(tag);
  endtask

  initial begin
    logic [23:0] f;
    int h;
    rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0; ldac_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset_frame_valid", frame_valid, 0);
    chk("reset_frame_error", frame_error, 0);
    chk("reset_cmd_error", cmd_error, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Write-and-update D at sck = clk/8.
    full_frame("wr_upd_d", 24'h38ABCD, 4);

    // Input write to A, then LDAC edge copies once; held-low LDAC does not re-copy.
    full_frame("wr_in_a", 24'h016050, $urandom_range(4, 6));
    ldac_n = 1'b0;
    @(negedge clk);
    chk("ldac_before_sync_dac_a", dac_a, 16'h0000);
    repeat (9) @(negedge clk);
    model_ldac();
    check_state("ldac_copy");
    full_frame("ldac_held_low", 24'h01BEEF, 4);
    ldac_n = 1'b1;
    repeat (4) @(negedge clk);

    // 23-bit frame is rejected, then a good frame to all four channels.
    spi_bits(24'h3F1234, 23, 5);
    finish_frame(0);
    chk_pulses("short_frame", 0, 1, 0);
    check_state("short_frame");
    full_frame("wr_upd_all4", 24'h3F1234, 4);

    // Unsupported command.
    full_frame("bad_cmd", 24'h5F0001, 4);

    // Reset mid-frame with ss held low; nothing from the partial frame may surface.
    spi_bits(24'hA5C3F0, 12, 4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check_state("mid_reset");
    rst = 1'b0;
    spi_bits(24'h5A5A5A, 12, 4);
    finish_frame(0);
    chk_pulses("after_mid_reset", 0, 0, 0);
    check_state("after_mid_reset");
    full_frame("wr_upd_all_b", 24'h320042, 4);

    // LDAC fall landing in the commit cycle sees the just-written input of C.
    full_frame("pre_ldac_wr_a", 24'h010999, 4);
    spi_bits(24'h040777, 24, 4);
    finish_frame(1);
    model_frame(24'h040777);
    model_ldac();
    chk_pulses("ldac_coincident", 1, 0, 0);
    chk("ldac_coincident_dac_c_at_valid", ob_dac_c, 16'h0777);
    check_state("ldac_coincident");
    ldac_n = 1'b1;
    repeat (4) @(negedge clk);

    // Random frames with occasional LDAC pulses.
    for (int n = 0; n < 10; n++) begin
      f = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 15)), 16'($urandom)};
      h = $urandom_range(4, 6);
      full_frame("rand_frame", f, h);
      if ($urandom_range(0, 2) == 0) begin
        ldac_n = 1'b0;
        repeat (6) @(negedge clk);
        ldac_n = 1'b1;
        repeat (4) @(negedge clk);
        model_ldac();
        check_state("rand_ldac");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
